// File: rtl/mem_bus_arbiter_if.sv
// Handshake bundle between the fetch/load-store requesters, the arbiter and the shared memory bus.
// The master view is the arbiter; the slave view is the surrounding requesters and memory.
interface mem_bus_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_cancel;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport master (
      input  inst_req, inst_addr, inst_cancel,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport slave (
      output inst_req, inst_addr, inst_cancel,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one memory bus with a single outstanding
// transaction; data wins ties but may starve a waiting fetch for at most MAX_DATA_RUN grants.
module mem_bus_arbiter #(
   parameter int unsigned MAX_DATA_RUN = 4
) (
   input logic              clk,
   input logic              rst,
   mem_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic       OWNER_INST = 1'b0;
   localparam logic       OWNER_DATA = 1'b1;
   localparam logic [3:0] RUN_LIMIT  = 4'(MAX_DATA_RUN);

   state_t      state_r;
   logic        owner_r;
   logic        drop_r;
   logic [3:0]  run_cnt_r;
   logic        mem_req_r;
   logic        mem_wr_r;
   logic [1:0]  mem_size_r;
   logic [3:0]  mem_wstrb_r;
   logic [31:0] mem_addr_r;
   logic [31:0] mem_wdata_r;

   logic        data_grant_s;
   logic        inst_grant_s;
   logic        addr_hit_s;
   logic        data_hit_s;

   // Grant decision, only meaningful while the bus is free
   always_comb begin
      data_grant_s = 1'b0;
      inst_grant_s = 1'b0;
      if (state_r == IDLE) begin
         if (bus.data_req && (!bus.inst_req || (run_cnt_r < RUN_LIMIT))) begin
            data_grant_s = 1'b1;
         end else if (bus.inst_req && !bus.inst_cancel) begin
            inst_grant_s = 1'b1;
         end else begin
            data_grant_s = 1'b0;
            inst_grant_s = 1'b0;
         end
      end else begin
         data_grant_s = 1'b0;
         inst_grant_s = 1'b0;
      end
   end

   // Handshake returns are combinational so the owner sees acceptance in the same cycle
   always_comb begin
      addr_hit_s = !rst && (state_r == REQ)  && bus.mem_addr_ok;
      data_hit_s = !rst && (state_r == RESP) && bus.mem_data_ok;
   end

   assign bus.inst_addr_ok = addr_hit_s && (owner_r == OWNER_INST);
   assign bus.data_addr_ok = addr_hit_s && (owner_r == OWNER_DATA);
   assign bus.inst_data_ok = data_hit_s && (owner_r == OWNER_INST) && !drop_r && !bus.inst_cancel;
   assign bus.data_data_ok = data_hit_s && (owner_r == OWNER_DATA);
   assign bus.inst_rdata   = bus.mem_rdata;
   assign bus.data_rdata   = bus.mem_rdata;

   assign bus.mem_req   = mem_req_r;
   assign bus.mem_wr    = mem_wr_r;
   assign bus.mem_size  = mem_size_r;
   assign bus.mem_wstrb = mem_wstrb_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;

   // Transaction FSM with captured request fields, fairness counter and fetch-drop flag
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         owner_r     <= OWNER_INST;
         drop_r      <= 1'b0;
         run_cnt_r   <= 4'd0;
         mem_req_r   <= 1'b0;
         mem_wr_r    <= 1'b0;
         mem_size_r  <= 2'b00;
         mem_wstrb_r <= 4'h0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
      end else begin
         unique case (state_r)
            IDLE: begin
               drop_r <= 1'b0;
               if (data_grant_s) begin
                  owner_r     <= OWNER_DATA;
                  mem_req_r   <= 1'b1;
                  mem_wr_r    <= bus.data_wr;
                  mem_size_r  <= bus.data_size;
                  mem_wstrb_r <= bus.data_wstrb;
                  mem_addr_r  <= bus.data_addr;
                  mem_wdata_r <= bus.data_wdata;
                  state_r     <= REQ;
               end else if (inst_grant_s) begin
                  owner_r     <= OWNER_INST;
                  mem_req_r   <= 1'b1;
                  mem_wr_r    <= 1'b0;
                  mem_size_r  <= 2'b10;
                  mem_wstrb_r <= 4'h0;
                  mem_addr_r  <= bus.inst_addr;
                  mem_wdata_r <= 32'h0000_0000;
                  state_r     <= REQ;
               end else begin
                  state_r <= IDLE;
               end
               // The run only counts data grants that made a fetch wait
               if (inst_grant_s || !bus.inst_req) begin
                  run_cnt_r <= 4'd0;
               end else if (data_grant_s && (run_cnt_r < RUN_LIMIT)) begin
                  run_cnt_r <= run_cnt_r + 4'd1;
               end else begin
                  run_cnt_r <= run_cnt_r;
               end
            end
            REQ: begin
               if ((owner_r == OWNER_INST) && bus.inst_cancel) begin
                  drop_r <= 1'b1;
               end
               if (bus.mem_addr_ok) begin
                  mem_req_r <= 1'b0;
                  state_r   <= RESP;
               end
            end
            RESP: begin
               if (bus.mem_data_ok) begin
                  drop_r  <= 1'b0;
                  state_r <= IDLE;
               end else if ((owner_r == OWNER_INST) && bus.inst_cancel) begin
                  drop_r <= 1'b1;
               end
            end
            default: begin
               mem_req_r <= 1'b0;
               drop_r    <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model is compared with the DUT on
// every falling edge, and hand-computed literals pin the key scenarios.
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter #(.MAX_DATA_RUN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   localparam byte G_I = 8'h49;
   localparam byte G_D = 8'h44;

   // transaction-level model: at most one transaction in flight
   bit          m_busy = 1'b0;
   bit          m_acc;
   bit          m_drop;
   bit          m_data;
   bit          m_wr;
   logic [1:0]  m_size;
   logic [3:0]  m_wstrb;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   int          m_streak = 0;
   byte         grant_log[$];
   int          inst_ok_seen = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      bit en_req, e_iao, e_dao, e_ido, e_ddo;
      en_req = m_busy && !m_acc;
      e_iao  = !rst && en_req && !m_data && bus.mem_addr_ok;
      e_dao  = !rst && en_req &&  m_data && bus.mem_addr_ok;
      e_ido  = !rst && m_busy && m_acc && !m_data && bus.mem_data_ok && !m_drop && !bus.inst_cancel;
      e_ddo  = !rst && m_busy && m_acc &&  m_data && bus.mem_data_ok;
      chk1("mem_req", bus.mem_req, en_req);
      if (en_req) begin
         chk1("mem_wr", bus.mem_wr, m_wr);
         chk32("mem_size", 32'(bus.mem_size), 32'(m_size));
         chk32("mem_wstrb", 32'(bus.mem_wstrb), 32'(m_wstrb));
         chk32("mem_addr", bus.mem_addr, m_addr);
         chk32("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk1("inst_addr_ok", bus.inst_addr_ok, e_iao);
      chk1("data_addr_ok", bus.data_addr_ok, e_dao);
      chk1("inst_data_ok", bus.inst_data_ok, e_ido);
      chk1("data_data_ok", bus.data_data_ok, e_ddo);
      if (e_ido) chk32("inst_rdata", bus.inst_rdata, bus.mem_rdata);
      if (e_ddo) chk32("data_rdata", bus.data_rdata, bus.mem_rdata);
      if (bus.inst_data_ok === 1'b1) inst_ok_seen++;
   endtask

   task automatic model_advance();
      if (rst) begin
         m_busy   = 1'b0;
         m_streak = 0;
      end else if (!m_busy) begin
         if (bus.data_req && (!bus.inst_req || m_streak < 4)) begin
            m_busy = 1'b1; m_acc = 1'b0; m_drop = 1'b0; m_data = 1'b1;
            m_wr = bus.data_wr; m_size = bus.data_size; m_wstrb = bus.data_wstrb;
            m_addr = bus.data_addr; m_wdata = bus.data_wdata;
            m_streak = bus.inst_req ? m_streak + 1 : 0;
            grant_log.push_back(G_D);
         end else if (bus.inst_req && !bus.inst_cancel) begin
            m_busy = 1'b1; m_acc = 1'b0; m_drop = 1'b0; m_data = 1'b0;
            m_wr = 1'b0; m_size = 2'b10; m_wstrb = 4'h0;
            m_addr = bus.inst_addr; m_wdata = 32'h0;
            m_streak = 0;
            grant_log.push_back(G_I);
         end else if (!bus.inst_req) begin
            m_streak = 0;
         end
      end else begin
         if (!m_data && bus.inst_cancel) m_drop = 1'b1;
         if (!m_acc) begin
            if (bus.mem_addr_ok) m_acc = 1'b1;
         end else if (bus.mem_data_ok) begin
            m_busy = 1'b0;
         end
      end
   endtask

   // single compare process: check against the model, then advance it past the coming edge
   initial begin
      forever begin
         @(negedge clk);
         model_compare();
         model_advance();
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      string exp_seq;
      int    mark;
      bus.inst_req = 1'b0; bus.inst_addr = 32'h0; bus.inst_cancel = 1'b0;
      bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'b00;
      bus.data_wstrb = 4'h0; bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
      bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
      rst = 1'b1;
      step(2);
      #3;
      chk1("rst_mem_req", bus.mem_req, 1'b0);
      chk32("rst_mem_addr", bus.mem_addr, 32'h0);
      chk1("rst_inst_addr_ok", bus.inst_addr_ok, 1'b0);
      rst = 1'b0; bus.mem_addr_ok = 1'b0;
      step();

      // single fetch: grant, address, data over three cycles
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0000;
      step();
      bus.mem_addr_ok = 1'b1; #3;
      chk1("t1_mem_req", bus.mem_req, 1'b1);
      chk32("t1_mem_addr", bus.mem_addr, 32'h1C00_0000);
      chk1("t1_mem_wr", bus.mem_wr, 1'b0);
      chk1("t1_inst_addr_ok", bus.inst_addr_ok, 1'b1);
      step();
      bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0280_0000; #3;
      chk1("t1_inst_data_ok", bus.inst_data_ok, 1'b1);
      chk32("t1_inst_rdata", bus.inst_rdata, 32'h0280_0000);
      chk1("t1_mem_req_resp", bus.mem_req, 1'b0);
      step();
      bus.mem_data_ok = 1'b0;
      step();

      // simultaneous fetch and store: store first, fetch on the following idle
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0040;
      bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = 2'b10;
      bus.data_wstrb = 4'hF; bus.data_addr = 32'h0000_1000; bus.data_wdata = 32'hDEAD_BEEF;
      bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0;
      step(); #3;
      chk1("t2_mem_wr", bus.mem_wr, 1'b1);
      chk32("t2_mem_addr", bus.mem_addr, 32'h0000_1000);
      chk32("t2_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
      chk1("t2_data_addr_ok", bus.data_addr_ok, 1'b1);
      chk1("t2_inst_addr_ok", bus.inst_addr_ok, 1'b0);
      step();
      bus.data_req = 1'b0; #3;
      chk1("t2_data_data_ok", bus.data_data_ok, 1'b1);
      step(2); #3;
      chk32("t2_fetch_addr", bus.mem_addr, 32'h1C00_0040);
      chk1("t2_fetch_addr_ok", bus.inst_addr_ok, 1'b1);
      step();
      bus.inst_req = 1'b0;
      step();
      bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
      step();

      // continuous contention: four data grants, then the fetch, then data again
      grant_log.delete();
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0100;
      bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h0000_2000;
      bus.data_wstrb = 4'h0; bus.data_wdata = 32'h0;
      bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hA5A5_0000;
      step(17);
      bus.inst_req = 1'b0; bus.data_req = 1'b0;
      step(2);
      bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0;
      exp_seq = "DDDDID";
      chk32("t3_grant_count", 32'(grant_log.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         chk32($sformatf("t3_grant%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));
      step();

      // fetch cancelled during the response phase, data arrives two cycles later
      mark = inst_ok_seen;
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0080; bus.mem_addr_ok = 1'b1;
      step(2);
      bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.inst_cancel = 1'b1;
      step();
      bus.inst_cancel = 1'b0;
      step();
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hBADB_AD00; #3;
      chk1("t4_inst_data_ok", bus.inst_data_ok, 1'b0);
      step();
      bus.mem_data_ok = 1'b0;
      chk32("t4_no_inst_ok", 32'(inst_ok_seen - mark), 32'd0);
      bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_size = 2'b10;
      bus.data_addr = 32'h0000_3000; bus.mem_addr_ok = 1'b1;
      step(); #3;
      chk1("t4_data_addr_ok", bus.data_addr_ok, 1'b1);
      step();
      bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h1122_3344; #3;
      chk1("t4_data_data_ok", bus.data_data_ok, 1'b1);
      chk32("t4_data_rdata", bus.data_rdata, 32'h1122_3344);
      step();
      bus.mem_data_ok = 1'b0;
      step();

      // address stall of five cycles with a cancel inside it
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_00C0;
      step();
      for (int i = 0; i < 5; i++) begin
         bus.inst_cancel = (i == 2);
         #3;
         chk1($sformatf("t5_mem_req%0d", i), bus.mem_req, 1'b1);
         chk32($sformatf("t5_mem_addr%0d", i), bus.mem_addr, 32'h1C00_00C0);
         chk1($sformatf("t5_no_addr_ok%0d", i), bus.inst_addr_ok, 1'b0);
         step();
      end
      bus.inst_cancel = 1'b0; bus.mem_addr_ok = 1'b1; #3;
      chk1("t5_inst_addr_ok", bus.inst_addr_ok, 1'b1);
      step();
      bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h0000_0055; #3;
      chk1("t5_inst_data_ok", bus.inst_data_ok, 1'b0);
      step();
      bus.mem_data_ok = 1'b0;
      step();

      // cancel in the same cycle as the response
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0100; bus.mem_addr_ok = 1'b1;
      step(2);
      bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b1; bus.inst_cancel = 1'b1; #3;
      chk1("t6_inst_data_ok", bus.inst_data_ok, 1'b0);
      step();
      bus.inst_cancel = 1'b0; bus.mem_data_ok = 1'b0;
      step();

      // cancel while idle blocks the fetch grant
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0140; bus.inst_cancel = 1'b1;
      step(); #3;
      chk1("t7_mem_req_a", bus.mem_req, 1'b0);
      step(); #3;
      chk1("t7_mem_req_b", bus.mem_req, 1'b0);
      bus.inst_cancel = 1'b0;
      step();
      bus.mem_addr_ok = 1'b1; #3;
      chk32("t7_mem_addr", bus.mem_addr, 32'h1C00_0140);
      step();
      bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
      step();
      bus.mem_data_ok = 1'b0;
      step();

      // reset in the response phase, then a stray response
      bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h0000_4000;
      bus.mem_addr_ok = 1'b1;
      step(2);
      bus.data_req = 1'b0; bus.mem_addr_ok = 1'b0; rst = 1'b1; bus.mem_data_ok = 1'b1; #3;
      chk1("t8_data_ok_in_rst", bus.data_data_ok, 1'b0);
      step();
      rst = 1'b0; #3;
      chk1("t8_stray_data_ok", bus.data_data_ok, 1'b0);
      chk1("t8_mem_req", bus.mem_req, 1'b0);
      step();
      bus.mem_data_ok = 1'b0;
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1C00_0200; bus.mem_addr_ok = 1'b1;
      step(); #3;
      chk1("t8_after_rst_mem_req", bus.mem_req, 1'b1);
      step();
      bus.inst_req = 1'b0; bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b1;
      step();
      bus.mem_data_ok = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
